// File: rtl/fp_pkg.sv
// fp_pkg: shared single-precision field widths, constants, FSM states and field-unpack type.
package fp_pkg;
  localparam int EXP_W = 8;
  localparam int FRAC_W = 23;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'd255;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  typedef enum logic [2:0] {IDLE, ALIGN, ARITH, NORM, ROUND, DONE} state_t;
  typedef struct packed {
    logic sign;
    logic [EXP_W-1:0] exp;
    logic [FRAC_W-1:0] frac;
  } fp_t;
endpackage

// File: rtl/fp_align_shift.sv
// fp_align_shift: right-shifts a 24-bit mantissa into a 27-bit mantissa+guard+round+sticky field.
// Ports: mant (24b hidden-bit mantissa), sh (shift amount), out (27b shifted field, bit 0 is sticky).
module fp_align_shift (
  input  logic [23:0] mant,
  input  logic [7:0]  sh,
  output logic [26:0] out
);
  logic [26:0] full, sft;
  logic lost;
  always_comb begin
    full = {mant, 3'b000};
    sft = full >> sh;
    lost = |(full & ((27'd1 << sh) - 27'd1));
    out = (sh >= 8'd26) ? {26'd0, |mant} : {sft[26:1], sft[0] | lost};
  end
endmodule

// File: rtl/fp_sub_seq.sv
// fp_sub_seq: multi-cycle IEEE-754 single-precision subtractor z = a - b with valid/ready handshakes.
// Ports: clk, rst_n (async active-low), a/b operands with in_valid/in_ready, z result with out_valid/out_ready.
// Parameter NORM_MAX bounds left-normalization shifts. Define FP_SUB_ROUND_EN for round-to-nearest-even
// (adds a ROUND state); otherwise the result is truncated.
module fp_sub_seq
  import fp_pkg::*;
#(
  parameter int NORM_MAX = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] z,
  output logic        out_valid,
  input  logic        out_ready
);
  state_t state, state_n;
  fp_t a_in, b_in, a_r, b_r, xf, yf;
  logic a_nan, b_nan, a_inf, b_inf, special, swap, x_s, y_s, z_ld, norm_kill, cnt_full;
  logic [31:0] spec_z, z_n, z_r;
  logic [23:0] a_m, b_m, x_m;
  logic [26:0] y_m, y_sh;
  logic [27:0] m, sum, m_r, m_l;
  logic [7:0] x_e, e_inc, e_dec, diff, cnt;
`ifdef FP_SUB_ROUND_EN
  logic inc;
  logic [24:0] r25;
`endif
  assign a_in = a;
  assign b_in = b;
  assign z = z_r;
  fp_align_shift u_shift (.mant(swap ? a_m : b_m), .sh(diff), .out(y_sh));
  always_comb begin
    a_nan = (a_in.exp == EXP_MAX) && (a_in.frac != '0);
    b_nan = (b_in.exp == EXP_MAX) && (b_in.frac != '0);
    a_inf = (a_in.exp == EXP_MAX) && (a_in.frac == '0);
    b_inf = (b_in.exp == EXP_MAX) && (b_in.frac == '0);
    special = a_nan | b_nan | a_inf | b_inf;
    spec_z = (a_nan | b_nan | (a_inf & b_inf & (a_in.sign == b_in.sign))) ? QNAN :
             a_inf ? {a_in.sign, EXP_MAX, 23'd0} : {~b_in.sign, EXP_MAX, 23'd0};
    // exponent 0 flushes the whole operand to zero, denormal fraction included
    a_m = (a_r.exp == '0) ? 24'd0 : {1'b1, a_r.frac};
    b_m = (b_r.exp == '0) ? 24'd0 : {1'b1, b_r.frac};
    swap = {b_r.exp, b_m} > {a_r.exp, a_m};
    xf = swap ? b_r : a_r;
    yf = swap ? a_r : b_r;
    diff = xf.exp - yf.exp;
    sum = (x_s == y_s) ? {1'b0, x_m, 3'b000} + {1'b0, y_m} : {1'b0, x_m, 3'b000} - {1'b0, y_m};
    m_r = {1'b0, m[27:2], m[1] | m[0]};
    m_l = {m[26:0], 1'b0};
    e_inc = x_e + 8'd1;
    e_dec = x_e - 8'd1;
    cnt_full = int'(cnt) + 1 >= NORM_MAX;
    norm_kill = !m[27] && !m[26] && (m == '0 || e_dec == '0 || cnt_full);
`ifdef FP_SUB_ROUND_EN
    inc = m[2] & (m[3] | m[1] | m[0]);
    r25 = {1'b0, m[26:3]} + {24'd0, inc};
`endif
  end
  always_comb begin
    state_n = state;
    z_n = z_r;
    z_ld = 1'b0;
    in_ready = state == IDLE;
    out_valid = state == DONE;
    case (state)
      IDLE: if (in_valid) begin
        state_n = special ? DONE : ALIGN;
        z_n = spec_z;
        z_ld = special;
      end
      ALIGN: state_n = ARITH;
      ARITH: state_n = NORM;
      NORM: if (m[27] || m[26] || norm_kill) begin
`ifdef FP_SUB_ROUND_EN
        state_n = ROUND;
`else
        state_n = DONE;
        z_ld = 1'b1;
        z_n = norm_kill ? 32'd0 :
              m[27] ? ((e_inc == EXP_MAX) ? {x_s, EXP_MAX, 23'd0} : {x_s, e_inc, m[26:4]}) :
              {x_s, x_e, m[25:3]};
`endif
      end
`ifdef FP_SUB_ROUND_EN
      // a forced-zero result arrives here with m cleared; x_e==MAX marks a normalization overflow
      ROUND: begin
        state_n = DONE;
        z_ld = 1'b1;
        z_n = (x_e == EXP_MAX) ? {x_s, EXP_MAX, 23'd0} :
              !m[26] ? 32'd0 :
              r25[24] ? ((e_inc == EXP_MAX) ? {x_s, EXP_MAX, 23'd0} : {x_s, e_inc, r25[23:1]}) :
              {x_s, x_e, r25[22:0]};
      end
`endif
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= '0;
      b_r <= '0;
      x_s <= 1'b0;
      y_s <= 1'b0;
      x_e <= '0;
      x_m <= '0;
      y_m <= '0;
      m <= '0;
      cnt <= '0;
      z_r <= '0;
    end else begin
      if (z_ld) z_r <= z_n;
      case (state)
        IDLE: if (in_valid) begin
          a_r <= a;
          b_r <= {~b[31], b[30:0]};
        end
        ALIGN: begin
          x_s <= xf.sign;
          y_s <= yf.sign;
          x_e <= xf.exp;
          x_m <= swap ? b_m : a_m;
          y_m <= y_sh;
          cnt <= '0;
        end
        ARITH: m <= sum;
        NORM: if (m[27]) begin
          m <= m_r;
          x_e <= e_inc;
        end else if (norm_kill) m <= '0;
        else if (!m[26]) begin
          m <= m_l;
          x_e <= e_dec;
          cnt <= cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end
endmodule
